// File: rtl/sad_search_ctrl.sv
// Block-matching search controller. It sums the per-beat SAD returned by an
// external combinational core over NUM_BLK candidate blocks and reports the lowest sum.
module sad_search_ctrl #(
    parameter int N_BEATS = 16,
    parameter int NUM_BLK = 4,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_ref,
    input  logic [7:0]       in_cand,
    output logic [1:0]       core_ref,
    output logic [7:0]       core_cand,
    input  logic [2:0]       core_sad,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] best_sad,
    output logic [3:0]       best_idx,
    output logic             sat,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int              BW        = $clog2(N_BEATS);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(N_BEATS - 1);
    localparam logic [BW-1:0]   ONE_BEAT  = BW'(1);
    localparam logic [3:0]      LAST_BLK  = 4'(NUM_BLK - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [ACC_W-1:0] acc_r;
    logic [BW-1:0]    beat_cnt_r;
    logic [3:0]       blk_cnt_r;
    logic [ACC_W-1:0] best_sad_r;
    logic [3:0]       best_idx_r;
    logic             sat_r;

    logic [ACC_W:0]   sum_s;
    logic             ovf_s;
    logic [ACC_W-1:0] acc_nxt_s;
    logic             beat_acc_s;
    logic             last_beat_s;
    logic             last_blk_s;

    assign core_ref    = in_ref;
    assign core_cand   = in_cand;

    assign sum_s       = {1'b0, acc_r} + (ACC_W + 1)'(core_sad);
    assign ovf_s       = sum_s[ACC_W];
    assign acc_nxt_s   = ovf_s ? ACC_MAX : sum_s[ACC_W-1:0];
    assign beat_acc_s  = in_valid && (state_r == RUN);
    assign last_beat_s = (beat_cnt_r == LAST_BEAT);
    assign last_blk_s  = (blk_cnt_r == LAST_BLK);

    assign in_ready    = (state_r == RUN);
    assign out_valid   = (state_r == DONE);
    assign busy        = (state_r != IDLE);
    assign best_sad    = best_sad_r;
    assign best_idx    = best_idx_r;
    assign sat         = sat_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort outranks every other transition outside IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (abort && (state_r != IDLE)) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = start ? RUN : IDLE;
                RUN:     state_nxt_s = (beat_acc_s && last_beat_s) ? CMP : RUN;
                CMP:     state_nxt_s = last_blk_s ? DONE : RUN;
                DONE:    state_nxt_s = out_ready ? IDLE : DONE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Accumulator, counters and best-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= {ACC_W{1'b0}};
            beat_cnt_r <= {BW{1'b0}};
            blk_cnt_r  <= 4'd0;
            best_sad_r <= {ACC_W{1'b0}};
            best_idx_r <= 4'd0;
            sat_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r      <= {ACC_W{1'b0}};
                        beat_cnt_r <= {BW{1'b0}};
                        blk_cnt_r  <= 4'd0;
                        best_sad_r <= ACC_MAX;
                        best_idx_r <= 4'd0;
                        sat_r      <= 1'b0;
                    end
                end
                RUN: begin
                    if (!abort && beat_acc_s) begin
                        acc_r      <= acc_nxt_s;
                        beat_cnt_r <= beat_cnt_r + ONE_BEAT;
                        if (ovf_s) begin
                            sat_r <= 1'b1;
                        end
                    end
                end
                CMP: begin
                    if (!abort) begin
                        // Strict compare so a tie keeps the earlier block.
                        if (acc_r < best_sad_r) begin
                            best_sad_r <= acc_r;
                            best_idx_r <= blk_cnt_r;
                        end
                        if (!last_blk_s) begin
                            blk_cnt_r  <= blk_cnt_r + 4'd1;
                            acc_r      <= {ACC_W{1'b0}};
                            beat_cnt_r <= {BW{1'b0}};
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
